mux_rr_arbiter: RTL and testbench

// Shares one 4:1 data mux between four requesters. A round-robin arbiter drives
// the mux select and a one-hot grant. The selected data is presented downstream

---
 rtl/mux_rr_arbiter_pkg.sv | 30 +++
 rtl/mux_rr_arbiter_if.sv | 48 ++++
 rtl/mux_rr_arbiter_rr_pick4.sv | 43 ++++
 rtl/mux_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types, sizes and helpers for the 4-lane round-robin mux arbiter
//
// Contents:
//   N_REQ          number of requester lanes
//   SEL_W          width of the mux select / lane index
//   arb_state_t    arbiter FSM states
//   onehot_to_idx  converts a one-hot (or zero) lane vector into a lane index
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // An all-zero input maps to index 0. OR-ing indices is exact for one-hot input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/downstream bundle of the round-robin mux arbiter
//
// Signals:
//   req        lane requests, lane i holds req[i]=1 while it wants the mux
//   d          lane data, lane i at d[i*DW +: DW]
//   out_ready  downstream accepts y this cycle
//   gnt        one-hot (or zero) grant
//   sel        index of the granted lane, drives the mux
//   out_valid  y is valid, equals |gnt
//   y          data of the lane selected by sel
// Modports:
//   master     requesters plus downstream sink (drives req, d, out_ready)
//   slave      the arbiter itself (drives gnt, sel, out_valid, y)
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DW = 1
) ();

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] d;
  logic                out_ready;
  logic [N_REQ-1:0]    gnt;
  logic [SEL_W-1:0]    sel;
  logic                out_valid;
  logic [DW-1:0]       y;

  modport master (
    output req,
    output d,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  y
  );

  modport slave (
    input  req,
    input  d,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output y
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rtl/mux_rr_arbiter_rr_pick4.sv - combinational 4-lane rotating priority picker
//
// Ports:
//   req     in   4  lane requests
//   mask    in   4  lanes excluded from this pick
//   ptr     in   2  highest-priority lane; search order ptr, ptr+1, ... mod 4
//   any     out  1  at least one eligible lane
//   idx     out  2  winning lane index (0 when any=0)
//   onehot  out  4  winning lane as one-hot (zero when any=0)
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0]   elig;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_oh;
  logic [SEL_W-1:0]   rot_idx;
  logic [2*N_REQ-1:0] back_dbl;

  always_comb begin
    elig     = req & ~mask;
    // Rotate right by ptr so lane ptr sits at bit 0 and gets fixed priority.
    rot_dbl  = {elig, elig} >> ptr;
    rot      = rot_dbl[N_REQ-1:0];
    // Isolate the lowest set bit: the first eligible lane in search order.
    rot_oh   = rot & (~rot + 4'd1);
    rot_idx  = onehot_to_idx(rot_oh);
    // Undo the rotation; the 2-bit add wraps 3->0 by itself.
    idx      = rot_idx + ptr;
    back_dbl = {rot_oh, rot_oh} << ptr;
    onehot   = back_dbl[2*N_REQ-1:N_REQ];
    any      = |elig;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning the select lines of a shared 4:1 data mux
//
// Parameters:
//   DW        data width per requester lane
//   MAX_HOLD  accepted transfers a grantee may take before yielding to pending lanes (>=1)
// Ports:
//   clk    in     system clock, rising edge
//   rst_n  in     asynchronous active-low reset
//   bus    slave  req/d/out_ready in, gnt/sel/out_valid/y out (see mux_rr_arbiter_if)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;

  logic             xfer;
  logic             own_req;
  logic             others;
  logic [HW-1:0]    hold_inc;
  logic             rel_a;
  logic             rel_b;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;

  always_comb begin
    xfer     = (|gnt_q) & bus.out_ready;
    own_req  = |(bus.req & gnt_q);
    others   = |(bus.req & ~gnt_q);
    hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    // Grantee has gone away (also covers a drop during backpressure: data is dropped).
    rel_a    = (state == GRANT) && !own_req;
    // Quota used up on this very transfer and somebody else is waiting.
    rel_b    = (state == GRANT) && xfer && (hold_inc == HOLD_MAX) && others;
    // Only a quota release must hide the current owner; on rel_a its req is 0 anyway.
    pick_mask = rel_b ? gnt_q : '0;
  end

  rr_pick4 u_pick (
    .req    (bus.req),
    .mask   (pick_mask),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      sel_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q    <= pick_oh;
            sel_q    <= pick_idx;
            ptr      <= pick_idx + 2'd1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel_a || rel_b) begin
            if (pick_any) begin
              // Hand over directly, no idle cycle between owners.
              gnt_q    <= pick_oh;
              sel_q    <= pick_idx;
              ptr      <= pick_idx + 2'd1;
              hold_cnt <= '0;
            end else begin
              // sel keeps its last value so it only moves together with a new grant.
              gnt_q    <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end else if (xfer) begin
            // Saturates; a lone requester past its quota keeps the mux.
            hold_cnt <= hold_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    bus.y = bus.d[0*DW +: DW];
      2'd1:    bus.y = bus.d[1*DW +: DW];
      2'd2:    bus.y = bus.d[2*DW +: DW];
      default: bus.y = bus.d[3*DW +: DW];
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  localparam int DW       = 1;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  mux_rr_arbiter_if #(.DW(DW)) bus ();

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner lane (-1 = none), priority pointer, accepted-transfer count.
  int m_g;
  int m_sel;
  int m_ptr;
  int m_hold;
  int m_w;
  int m_nh;
  bit m_rb;
  logic [3:0] m_r;

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    int l;
    for (int k = 0; k < 4; k++) begin
      l = (p + k) % 4;
      if (r[l] && l != excl) return l;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else begin
      m_r = bus.req;
      if (m_g < 0) begin
        m_w = pick(m_r, m_ptr, -1);
        if (m_w >= 0) begin
          m_g = m_w; m_sel = m_w; m_ptr = (m_w + 1) % 4; m_hold = 0;
        end
      end else begin
        m_nh = bus.out_ready ? ((m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1) : m_hold;
        m_rb = bus.out_ready && (m_nh == MAX_HOLD) && ((m_r & ~(4'b0001 << m_g)) != 4'b0000);
        if (!m_r[m_g] || m_rb) begin
          m_w = pick(m_r, m_ptr, m_rb ? m_g : -1);
          if (m_w >= 0) begin
            m_g = m_w; m_sel = m_w; m_ptr = (m_w + 1) % 4; m_hold = 0;
          end else begin
            m_g = -1; m_hold = 0;
          end
        end else begin
          m_hold = m_nh;
        end
      end
    end
  end

  // Compare process: outputs are meaningful every cycle, including during reset.
  always @(negedge clk) begin
    check("model_gnt", bus.gnt, (m_g < 0) ? 32'd0 : (32'd1 << m_g));
    check("model_sel", bus.sel, m_sel);
    check("model_out_valid", bus.out_valid, (m_g >= 0) ? 32'd1 : 32'd0);
    check("model_y", bus.y, bus.d[m_sel]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int order[6] = '{0, 1, 2, 3, 0, 1};
  int lane;
  int n;
  logic [3:0] after_gnt;
  logic [3:0] prev_req;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.d = 4'b0000;
    bus.out_ready = 1'b1;

    // 1. Reset state and first grant.
    tick(); tick(); tick();
    check("reset_gnt", bus.gnt, 4'b0000);
    check("reset_sel", bus.sel, 2'd0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    check("first_gnt", bus.gnt, 4'b0001);

    // 2. Single lane, combinational y.
    apply_reset();
    bus.req = 4'b0100; bus.d = 4'b1010; bus.out_ready = 1'b1;
    tick();
    check("single_gnt", bus.gnt, 4'b0100);
    check("single_sel", bus.sel, 2'b10);
    check("single_y0", bus.y, 1'b0);
    bus.d = 4'b1101;
    #1;
    check("single_y1", bus.y, 1'b1);

    // 3. Round robin, each lane drops after one transfer and re-raises a cycle later.
    apply_reset();
    bus.req = 4'b1111; bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      lane = -1;
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) lane = i;
      check("rr_order", lane, order[k]);
      check("rr_no_bubble", bus.out_valid, 1'b1);
      prev_req = bus.req;
      for (int i = 0; i < 4; i++) begin
        if (bus.gnt[i]) bus.req[i] = 1'b0;
        else if (!prev_req[i]) bus.req[i] = 1'b1;
      end
    end

    // 4. Hold limit alternation, then a lone requester keeps the mux.
    apply_reset();
    bus.req = 4'b0011; bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      check("hold_alt", bus.gnt, ((k / 8) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    bus.req = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("hold_lone", bus.gnt, 4'b0001);
    end

    // 5. Backpressure freezes grant and hold count.
    apply_reset();
    bus.req = 4'b0010; bus.out_ready = 1'b0;
    tick();
    check("bp_gnt_start", bus.gnt, 4'b0010);
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      bus.d = 4'($urandom_range(0, 15));
      #1;
      check("bp_gnt", bus.gnt, 4'b0010);
      check("bp_y", bus.y, bus.d[1]);
      tick();
    end
    bus.out_ready = 1'b1;
    n = 0;
    after_gnt = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      if (bus.gnt == 4'b0010) n++;
      else if (after_gnt == 4'b0000) after_gnt = bus.gnt;
      tick();
    end
    check("bp_quota_after", n, 8);
    check("bp_next_gnt", after_gnt, 4'b0100);

    // 6. Asynchronous reset in the middle of a grant.
    apply_reset();
    bus.req = 4'b1000; bus.out_ready = 1'b1;
    tick();
    check("async_pre_gnt", bus.gnt, 4'b1000);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_gnt", bus.gnt, 4'b0000);
    check("async_out_valid", bus.out_valid, 1'b0);
    bus.req = 4'b1010;
    tick();
    rst_n = 1'b1;
    tick();
    check("async_regrant", bus.gnt, 4'b0010);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
